// File: rtl/md_ref_pkg.sv
// Shared types for the reference-particle prefetcher: per-axis cell IDs,
// queue entries, the pass-control state encoding and the coordinate width rule.
package md_ref_pkg;

  localparam int REF_OFFSET_WIDTH      = 29;
  localparam int REF_CELL_ID_WIDTH     = 3;
  localparam int REF_PARTICLE_ID_WIDTH = 7;
  localparam int REF_DATA_WIDTH        = REF_OFFSET_WIDTH + REF_CELL_ID_WIDTH;

  // An assembled coordinate is the cell ID sitting directly above the offset.
  function automatic int ref_data_width(input int offset_width, input int cell_id_width);
    return offset_width + cell_id_width;
  endfunction

  typedef struct packed {
    logic [REF_CELL_ID_WIDTH-1:0] idz;
    logic [REF_CELL_ID_WIDTH-1:0] idy;
    logic [REF_CELL_ID_WIDTH-1:0] idx;
  } cell_id_t;

  typedef struct packed {
    logic [REF_PARTICLE_ID_WIDTH-1:0] id;
    logic [REF_DATA_WIDTH-1:0]        x;
    logic [REF_DATA_WIDTH-1:0]        y;
    logic [REF_DATA_WIDTH-1:0]        z;
  } ref_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ref_state_e;

endpackage

// File: rtl/ref_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible whenever the queue
// is non-empty, and a push into a full queue is accepted if a pop happens too.
module ref_fifo
  import md_ref_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = ref_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty queue presents zeros so downstream never sees stale coordinates.
  assign head = empty ? entry_t'('0) : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ref_data_prefetcher.sv
// Captures home-cell broadcast particles in ID order into a prefetch queue and
// serves them as reference particles. REF_PREFETCH_STALL_CNT_EN builds the starvation counter.
module ref_data_prefetcher
  import md_ref_pkg::*;
#(
  parameter int OFFSET_WIDTH      = 29,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int DATA_WIDTH        = ref_data_width(OFFSET_WIDTH, CELL_ID_WIDTH),
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int DEPTH             = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         count_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0] count_in,
  input  logic                         bcast_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0] bcast_id,
  input  logic [OFFSET_WIDTH-1:0]      bcast_x,
  input  logic [OFFSET_WIDTH-1:0]      bcast_y,
  input  logic [OFFSET_WIDTH-1:0]      bcast_z,
  input  logic [CELL_ID_WIDTH-1:0]     cell_id_x,
  input  logic [CELL_ID_WIDTH-1:0]     cell_id_y,
  input  logic [CELL_ID_WIDTH-1:0]     cell_id_z,
  input  logic                         ref_ready,
  output logic                         ref_valid,
  output logic [DATA_WIDTH-1:0]        ref_x,
  output logic [DATA_WIDTH-1:0]        ref_y,
  output logic [DATA_WIDTH-1:0]        ref_z,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count,
  output logic                         all_refs_done,
  output logic [15:0]                  stall_cycles
);

  localparam int CNT_W = PARTICLE_ID_WIDTH + 1;

  typedef struct packed {
    logic [CELL_ID_WIDTH-1:0] idz;
    logic [CELL_ID_WIDTH-1:0] idy;
    logic [CELL_ID_WIDTH-1:0] idx;
  } home_cell_t;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]        x;
    logic [DATA_WIDTH-1:0]        y;
    logic [DATA_WIDTH-1:0]        z;
  } entry_t;

  ref_state_e                   state_q, state_d;
  logic [CNT_W-1:0]             capture_id_q, capture_id_d;
  logic [CNT_W-1:0]             consumed_q, consumed_d;
  logic [PARTICLE_ID_WIDTH-1:0] count_q, count_d;
  logic                         done_q, done_d;

  home_cell_t       home_cell;
  entry_t           push_entry;
  entry_t           head_entry;
  logic             fifo_full, fifo_empty;
  logic             push, pop, in_run;
  logic [CNT_W-1:0] count_ext, bcast_id_ext;

  assign home_cell    = {cell_id_z, cell_id_y, cell_id_x};
  assign in_run       = (state_q == ST_RUN);
  assign count_ext    = {1'b0, count_q};
  assign bcast_id_ext = {1'b0, bcast_id};
  assign ref_valid    = !fifo_empty;

  // A start in the same cycle flushes the queue, so neither side may move.
  assign pop  = in_run && ref_valid && ref_ready && !start;
  assign push = in_run && !start && bcast_valid
                && (bcast_id_ext == capture_id_q)
                && (capture_id_q <= count_ext)
                && (!fifo_full || pop);

  always_comb begin
    push_entry    = '0;
    push_entry.id = bcast_id;
    push_entry.x  = {home_cell.idx, bcast_x};
    push_entry.y  = {home_cell.idy, bcast_y};
    push_entry.z  = {home_cell.idz, bcast_z};
  end

  ref_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ref_x              = head_entry.x;
  assign ref_y              = head_entry.y;
  assign ref_z              = head_entry.z;
  assign ref_id             = head_entry.id;
  assign ref_particle_count = count_q;
  assign all_refs_done      = done_q;

  always_comb begin
    state_d      = state_q;
    capture_id_d = capture_id_q;
    consumed_d   = consumed_q;
    count_d      = count_q;
    done_d       = done_q;
    if (start) begin
      state_d      = ST_LOAD;
      capture_id_d = CNT_W'(1);
      consumed_d   = '0;
      done_d       = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (count_valid) begin
            count_d = count_in;
            if (count_in == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (push) begin
            capture_id_d = capture_id_q + CNT_W'(1);
          end
          if (pop) begin
            consumed_d = consumed_q + CNT_W'(1);
            if ((consumed_q + CNT_W'(1)) == count_ext) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      capture_id_q <= CNT_W'(1);
      consumed_q   <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      capture_id_q <= capture_id_d;
      consumed_q   <= consumed_d;
      count_q      <= count_d;
      done_q       <= done_d;
    end
  end

`ifdef REF_PREFETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Starvation: downstream is ready in RUN but nothing has been prefetched yet.
  always_comb begin
    stall_d = stall_q;
    if (start) begin
      stall_d = '0;
    end else if (in_run && ref_ready && !ref_valid && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_ref_data_prefetcher.sv
// Scoreboard bench for ref_data_prefetcher: directed passes push expected
// references into a queue, and a negedge monitor checks every handshake.
module tb_ref_data_prefetcher;

  localparam int OW = 29;
  localparam int CW = 3;
  localparam int DW = 32;
  localparam int PW = 7;

  localparam logic [CW-1:0] CX = 3'b010;
  localparam logic [CW-1:0] CY = 3'b101;
  localparam logic [CW-1:0] CZ = 3'b111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          count_valid = 1'b0;
  logic [PW-1:0] count_in = '0;
  logic          bcast_valid = 1'b0;
  logic [PW-1:0] bcast_id = '0;
  logic [OW-1:0] bcast_x = '0;
  logic [OW-1:0] bcast_y = '0;
  logic [OW-1:0] bcast_z = '0;
  logic [CW-1:0] cell_id_x = CX;
  logic [CW-1:0] cell_id_y = CY;
  logic [CW-1:0] cell_id_z = CZ;
  logic          ref_ready = 1'b0;
  logic          ref_valid;
  logic [DW-1:0] ref_x, ref_y, ref_z;
  logic [PW-1:0] ref_id;
  logic [PW-1:0] ref_particle_count;
  logic          all_refs_done;
  logic [15:0]   stall_cycles;

  typedef struct {
    int          id;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } exp_t;

  exp_t expQ[$];
  exp_t monEntry;
  int   testsRun = 0;
  int   testsFailed = 0;

  ref_data_prefetcher #(
    .OFFSET_WIDTH      (OW),
    .CELL_ID_WIDTH     (CW),
    .DATA_WIDTH        (DW),
    .PARTICLE_ID_WIDTH (PW),
    .DEPTH             (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .count_valid        (count_valid),
    .count_in           (count_in),
    .bcast_valid        (bcast_valid),
    .bcast_id           (bcast_id),
    .bcast_x            (bcast_x),
    .bcast_y            (bcast_y),
    .bcast_z            (bcast_z),
    .cell_id_x          (cell_id_x),
    .cell_id_y          (cell_id_y),
    .cell_id_z          (cell_id_z),
    .ref_ready          (ref_ready),
    .ref_valid          (ref_valid),
    .ref_x              (ref_x),
    .ref_y              (ref_y),
    .ref_z              (ref_z),
    .ref_id             (ref_id),
    .ref_particle_count (ref_particle_count),
    .all_refs_done      (all_refs_done),
    .stall_cycles       (stall_cycles)
  );

  always #5 clk = ~clk;

  // Distinct offsets per particle so misordered or mixed-up axes show up.
  function automatic logic [OW-1:0] offX(input int id);
    return OW'(id);
  endfunction
  function automatic logic [OW-1:0] offY(input int id);
    return 29'h0ABC_0000 + OW'(id);
  endfunction
  function automatic logic [OW-1:0] offZ(input int id);
    return 29'h1FFF_FF00 + OW'(id);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic pushExpected(input int id);
    exp_t e;
    e.id = id;
    e.x  = {CX, offX(id)};
    e.y  = {CY, offY(id)};
    e.z  = {CZ, offZ(id)};
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs, then advances past the next rising edge.
  task automatic applyStimulus(input logic st, input logic cv, input int cnt,
                               input logic bv, input int id, input logic rdy);
    start       = st;
    count_valid = cv;
    count_in    = PW'(cnt);
    bcast_valid = bv;
    bcast_id    = PW'(id);
    bcast_x     = offX(id);
    bcast_y     = offY(id);
    bcast_z     = offZ(id);
    ref_ready   = rdy;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && ref_valid && ref_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_ref: actual id=%0d required none", ref_id);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("mon_ref_id", 64'(ref_id), 64'(monEntry.id));
        checkOutput("mon_ref_x", 64'(ref_x), 64'(monEntry.x));
        checkOutput("mon_ref_y", 64'(ref_y), 64'(monEntry.y));
        checkOutput("mon_ref_z", 64'(ref_z), 64'(monEntry.z));
      end
    end
  end

  initial begin
    int seen;

    // Reset and idle: everything quiet.
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checkOutput("idle_ref_valid", 64'(ref_valid), 64'd0);
      tick();
    end
    checkOutput("idle_ref_x", 64'(ref_x), 64'd0);
    checkOutput("idle_ref_id", 64'(ref_id), 64'd0);
    checkOutput("idle_count", 64'(ref_particle_count), 64'd0);
    checkOutput("idle_done", 64'(all_refs_done), 64'd0);
    checkOutput("idle_stall", 64'(stall_cycles), 64'd0);

    // Basic pass of five with downstream always ready.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 1);
    for (int id = 1; id <= 5; id++) pushExpected(id);
    applyStimulus(0, 0, 0, 1, 1, 1);
    checkOutput("latency_valid", 64'(ref_valid), 64'd1);
    checkOutput("latency_id", 64'(ref_id), 64'd1);
    checkOutput("coord_example_x", 64'(ref_x), 64'h4000_0001);
    checkOutput("latched_count", 64'(ref_particle_count), 64'd5);
    for (int id = 2; id <= 5; id++) applyStimulus(0, 0, 0, 1, id, 1);
    checkOutput("done_before_last_pop", 64'(all_refs_done), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("done_after_last_pop", 64'(all_refs_done), 64'd1);
    checkOutput("valid_after_done", 64'(ref_valid), 64'd0);
    for (int id = 1; id <= 3; id++) applyStimulus(0, 0, 0, 1, id, 1);
    checkOutput("done_holds", 64'(all_refs_done), 64'd1);
    checkOutput("pass5_drained", 64'(expQ.size()), 64'd0);

    // Seven particles, four-deep queue, downstream stalled on first sweep.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("start_clears_done", 64'(all_refs_done), 64'd0);
    applyStimulus(0, 1, 7, 0, 0, 0);
    for (int id = 1; id <= 7; id++) pushExpected(id);
    for (int id = 1; id <= 7; id++) applyStimulus(0, 0, 0, 1, id, 0);
    checkOutput("full_head_valid", 64'(ref_valid), 64'd1);
    checkOutput("full_head_id", 64'(ref_id), 64'd1);
    applyStimulus(0, 0, 0, 1, 5, 1);
    checkOutput("push_pop_full_head", 64'(ref_id), 64'd2);
    applyStimulus(0, 0, 0, 1, 6, 0);
    checkOutput("stable_head_id", 64'(ref_id), 64'd2);
    checkOutput("stable_head_x", 64'(ref_x), 64'({CX, offX(2)}));
    seen = 0;
    ref_ready   = 1'b1;
    bcast_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ref_valid) seen++;
      tick();
    end
    checkOutput("occupancy_when_full", 64'(seen), 64'd4);
    for (int id = 1; id <= 7; id++) applyStimulus(0, 0, 0, 1, id, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("pass7_done", 64'(all_refs_done), 64'd1);
    checkOutput("pass7_drained", 64'(expQ.size()), 64'd0);

    // Empty cell: straight to DONE, never valid, stray count ignored.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("zero_done", 64'(all_refs_done), 64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 1);
      checkOutput("zero_no_valid", 64'(ref_valid), 64'd0);
    end
    applyStimulus(0, 1, 9, 0, 0, 0);
    checkOutput("count_outside_load", 64'(ref_particle_count), 64'd0);

    // Restart mid-RUN with a matching broadcast: queue flushed, broadcast dropped.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 2, 0);
    checkOutput("midrun_valid", 64'(ref_valid), 64'd1);
    applyStimulus(1, 0, 0, 1, 3, 0);
    checkOutput("flush_valid", 64'(ref_valid), 64'd0);
    checkOutput("flush_done", 64'(all_refs_done), 64'd0);
    expQ.delete();
    applyStimulus(0, 1, 2, 0, 0, 0);
    pushExpected(1);
    pushExpected(2);
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 1, 2, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("restart_done", 64'(all_refs_done), 64'd1);
    checkOutput("restart_drained", 64'(expQ.size()), 64'd0);

    // Starvation: ten ready cycles in RUN with nothing captured.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef REF_PREFETCH_STALL_CNT_EN
    checkOutput("stall_count", 64'(stall_cycles), 64'd10);
`else
    checkOutput("stall_count", 64'(stall_cycles), 64'd0);
`endif

    // Reset mid-pass clears everything with no leftover valid.
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 2, 0);
    checkOutput("prereset_valid", 64'(ref_valid), 64'd1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    checkOutput("rst_valid", 64'(ref_valid), 64'd0);
    checkOutput("rst_id", 64'(ref_id), 64'd0);
    checkOutput("rst_x", 64'(ref_x), 64'd0);
    checkOutput("rst_count", 64'(ref_particle_count), 64'd0);
    checkOutput("rst_done", 64'(all_refs_done), 64'd0);
    checkOutput("rst_stall", 64'(stall_cycles), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 3, 1);
      checkOutput("post_rst_valid", 64'(ref_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
